pe_psum_acc: RTL and testbench

Partial-sum collector on the output side of the 7x3 row-convolution PE array. It accepts the PE's 9-lane, 32-bit partial-sum vector once per kernel row and accumulates TAPS consecutive vectors (one per kernel row of a 3x3 filter) on top of a per-channel bias. It then presents the finished 9-lane output row to the downstream requantization/write-back stage over a valid/ready handshake. Because the output stage is registered, accumulation of the next row proceeds at full rate while the previous result waits.

---
 rtl/pe_psum_acc_if.sv | 34 +++
 rtl/pe_psum_acc.sv | 89 ++++++++
 tb/tb_pe_psum_acc.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/pe_psum_acc_if.sv
// Handshake bundle between the PE array, the partial-sum
// collector and the requantization/write-back stage.
interface pe_psum_acc_if #(
  parameter int N_LANE = 9,
  parameter int ACC_W  = 32
);
  logic                    psum_valid;
  logic                    psum_ready;
  logic [N_LANE*ACC_W-1:0] psum_i;
  logic [ACC_W-1:0]        bias_i;
  logic                    out_valid;
  logic                    out_ready;
  logic [N_LANE*ACC_W-1:0] out_data;

  modport master (
    output psum_valid,
    output psum_i,
    output bias_i,
    output out_ready,
    input  psum_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  psum_valid,
    input  psum_i,
    input  bias_i,
    input  out_ready,
    output psum_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/pe_psum_acc.sv
// Partial-sum collector: sums TAPS PE result vectors on top of a
// per-channel bias and hands finished rows downstream.
module pe_psum_acc #(
  parameter int N_LANE = 9,
  parameter int ACC_W  = 32,
  parameter int TAPS   = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  pe_psum_acc_if.slave   bus,
  output logic [3:0]     tap_cnt,
  output logic           ovf_o
);

  typedef logic [N_LANE-1:0][ACC_W-1:0] vec_t;

  localparam logic [3:0] LAST = 4'(TAPS - 1);

  vec_t acc;
  vec_t out_q;
  vec_t psum;
  vec_t base;
  vec_t sum;
  logic out_v;
  logic first;
  logic last;
  logic acc_fire;
  logic out_fire;
  logic ovf_any;

  assign psum          = bus.psum_i;
  assign bus.out_data  = out_q;
  assign bus.out_valid = out_v;

  assign first = (tap_cnt == 4'd0);
  assign last  = (tap_cnt == LAST);

  // Only the closing tap needs the output register, so only it stalls.
  assign bus.psum_ready = !(last && out_v && !bus.out_ready);

  assign acc_fire = bus.psum_valid && bus.psum_ready;
  assign out_fire = out_v && bus.out_ready;

  always_comb begin
    base    = '0;
    sum     = '0;
    ovf_any = 1'b0;
    for (int k = 0; k < N_LANE; k++) begin
      base[k] = first ? bus.bias_i : acc[k];
      sum[k]  = base[k] + psum[k];
      ovf_any = ovf_any
              | ((base[k][ACC_W-1] == psum[k][ACC_W-1])
              &  (sum[k][ACC_W-1] != base[k][ACC_W-1]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      out_q   <= '0;
      out_v   <= 1'b0;
      tap_cnt <= 4'd0;
      ovf_o   <= 1'b0;
    end else if (clear) begin
      out_v   <= 1'b0;
      tap_cnt <= 4'd0;
      ovf_o   <= 1'b0;
    end else begin
      if (out_fire) begin
        out_v <= 1'b0;
      end
      if (acc_fire) begin
        if (ovf_any) begin
          ovf_o <= 1'b1;
        end
        if (last) begin
          out_q   <= sum;
          out_v   <= 1'b1;
          tap_cnt <= 4'd0;
        end else begin
          acc     <= sum;
          tap_cnt <= tap_cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_psum_acc.sv
// Scoreboard bench for pe_psum_acc: directed rows plus randomized
// traffic against a plain-arithmetic row model.
module tb_pe_psum_acc;

  localparam int N    = 9;
  localparam int W    = 32;
  localparam int TAPS = 3;

  typedef logic [N*W-1:0] vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] tap_cnt;
  logic       ovf_o;

  pe_psum_acc_if #(.N_LANE(N), .ACC_W(W)) bus ();

  pe_psum_acc #(.N_LANE(N), .ACC_W(W), .TAPS(TAPS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .bus     (bus),
    .tap_cnt (tap_cnt),
    .ovf_o   (ovf_o)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   rows   = 0;
  vec_t exp_q[$];

  // reference model state
  int   taps_m = 0;
  bit   ovf_m  = 0;
  longint run_m [N];
  bit   fired;

  task automatic chk(input string nm, input vec_t act, input vec_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_row: got %h expected none", bus.out_data);
      end else begin
        chk("row_data", bus.out_data, exp_q[0]);
        if (bus.out_ready) begin
          void'(exp_q.pop_front());
          rows++;
        end
      end
    end
  end

  task automatic model_step(input bit c, input vec_t p, input logic [W-1:0] b);
    vec_t   row;
    longint t;
    if (c) begin
      taps_m = 0;
      ovf_m  = 0;
      exp_q.delete();
    end else if (fired) begin
      if (taps_m == 0)
        for (int k = 0; k < N; k++) run_m[k] = longint'($signed(b));
      for (int k = 0; k < N; k++) begin
        t = run_m[k] + longint'($signed(p[k*W +: W]));
        if (t > 64'sd2147483647 || t < -64'sd2147483648) ovf_m = 1;
        run_m[k] = longint'($signed(t[W-1:0]));
      end
      taps_m++;
      if (taps_m == TAPS) begin
        row = '0;
        for (int k = 0; k < N; k++) begin
          t = run_m[k];
          row[k*W +: W] = t[W-1:0];
        end
        exp_q.push_back(row);
        taps_m = 0;
      end
    end
  endtask

  task automatic send(input bit v, input vec_t p, input logic [W-1:0] b,
                      input bit orr, input bit c);
    bus.psum_valid = v;
    bus.psum_i     = p;
    bus.bias_i     = b;
    bus.out_ready  = orr;
    clear          = c;
    @(negedge clk);
    #1;
    fired = v && bus.psum_ready && !c;
    model_step(c, p, b);
    @(posedge clk);
    #1;
    chk("tap_cnt", vec_t'(tap_cnt), vec_t'(taps_m));
    chk("ovf_o", vec_t'(ovf_o), vec_t'(ovf_m));
  endtask

  function automatic vec_t fill(input logic [W-1:0] a, input int mul);
    vec_t r = '0;
    for (int k = 0; k < N; k++) r[k*W +: W] = a + W'(k * mul);
    return r;
  endfunction

  vec_t v;
  vec_t e;
  int   r0;

  initial begin
    bus.psum_valid = 1'b0;
    bus.psum_i     = '0;
    bus.bias_i     = '0;
    bus.out_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("rst_ready", vec_t'(bus.psum_ready), vec_t'(1));
    chk("rst_valid", vec_t'(bus.out_valid), vec_t'(0));
    chk("rst_data", bus.out_data, vec_t'(0));
    chk("rst_tap", vec_t'(tap_cnt), vec_t'(0));
    chk("rst_ovf", vec_t'(ovf_o), vec_t'(0));

    // basic row: lanes k, 2k, 3k on bias 10
    for (int m = 1; m <= 3; m++) send(1, fill(0, m), 32'd10, 1, 0);
    e = fill(32'd10, 6);
    chk("basic_valid", vec_t'(bus.out_valid), vec_t'(1));
    chk("basic_data", bus.out_data, e);
    send(0, '0, 0, 1, 0);
    chk("basic_pulse", vec_t'(bus.out_valid), vec_t'(0));

    // back-to-back rows
    r0 = rows;
    for (int i = 0; i < 12; i++) begin
      send(1, fill(1, 0), 0, 1, 0);
      chk("b2b_ready", vec_t'(fired), vec_t'(1));
      chk("b2b_pulse", vec_t'(bus.out_valid), vec_t'(i % 3 == 2));
    end
    send(0, '0, 0, 1, 0);
    chk("b2b_rows", vec_t'(rows - r0), vec_t'(4));

    // output stall across two rows
    for (int m = 1; m <= 3; m++) send(1, fill(W'(m), 1), 32'd5, 0, 0);
    for (int m = 1; m <= 2; m++) begin
      send(1, fill(W'(100 * m), 3), 32'd7, 0, 0);
      chk("stall_accept", vec_t'(fired), vec_t'(1));
    end
    chk("stall_ready_low", vec_t'(bus.psum_ready), vec_t'(0));
    for (int i = 0; i < 3; i++) begin
      send(1, fill(32'd300, 3), 32'd7, 0, 0);
      chk("stall_blocked", vec_t'(fired), vec_t'(0));
    end
    send(1, fill(32'd300, 3), 32'd7, 1, 0);
    chk("stall_reload", vec_t'(fired), vec_t'(1));
    chk("stall_no_gap", vec_t'(bus.out_valid), vec_t'(1));
    send(0, '0, 0, 1, 0);
    chk("stall_drained", vec_t'(bus.out_valid), vec_t'(0));

    // overflow on lane 0
    send(1, vec_t'(1), 32'h7FFF_FFFF, 1, 0);
    chk("ovf_set", vec_t'(ovf_o), vec_t'(1));
    send(1, '0, 0, 1, 0);
    send(1, '0, 0, 1, 0);
    chk("ovf_lane0", vec_t'(bus.out_data[W-1:0]), vec_t'(32'h8000_0000));
    send(0, '0, 0, 1, 0);
    chk("ovf_sticky", vec_t'(ovf_o), vec_t'(1));
    send(0, '0, 0, 1, 1);
    chk("ovf_cleared", vec_t'(ovf_o), vec_t'(0));

    // clear together with the closing tap
    send(1, fill(1, 1), 32'd3, 1, 0);
    send(1, fill(1, 1), 32'd3, 1, 0);
    send(1, fill(1, 1), 32'd3, 1, 1);
    chk("clr_valid", vec_t'(bus.out_valid), vec_t'(0));
    chk("clr_tap", vec_t'(tap_cnt), vec_t'(0));
    for (int m = 1; m <= 3; m++) send(1, fill(W'(m), 2), 32'd20, 1, 0);
    chk("clr_fresh", bus.out_data, fill(32'd26, 6));

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      v = '0;
      for (int k = 0; k < N; k++)
        v[k*W +: W] = ($urandom_range(0, 3) == 0) ? W'($urandom())
                    : W'($urandom_range(0, 255)) - 32'd128;
      send(bit'($urandom_range(0, 3) != 0), v, W'($urandom()),
           bit'($urandom_range(0, 2) != 0),
           bit'($urandom_range(0, 31) == 0));
    end
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) send(0, '0, 0, 1, 0);
    chk("drain", vec_t'(exp_q.size()), vec_t'(0));

    // async reset mid-row with a stalled output
    for (int m = 1; m <= 4; m++) send(1, fill(W'(m), 1), 32'd1, 0, 0);
    chk("ar_pending", vec_t'(bus.out_valid), vec_t'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", vec_t'(bus.out_valid), vec_t'(0));
    chk("ar_data", bus.out_data, vec_t'(0));
    chk("ar_tap", vec_t'(tap_cnt), vec_t'(0));
    chk("ar_ready", vec_t'(bus.psum_ready), vec_t'(1));
    exp_q.delete();
    taps_m = 0;
    ovf_m  = 0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    send(0, '0, 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
